apb3_two_master_arbiter: RTL and testbench
==========================================

// Module: apb3_two_master_arbiter
// PURPOSE
//  Shares one APB3 bus between two APB3 requesters. M0 is the AHB-to-APB3 bridge output;
//  M1 is a secondary master (DMA/debug). The block sits between the requesters and the
//  APB3 slave fabric. It arbitrates round-robin, regenerates the SETUP/ACCESS phases on
//  the shared bus, and applies a PREADY watchdog that ends hung transfers with PSLVERR.
// PARAMETERS
//  ADDR_WIDTH  32   PADDR width, all ports
//  DATA_WIDTH  32   PWDATA/PRDATA width, all ports
//  TIMEOUT     256  max ACCESS cycles without PREADY; 0 disables the watchdog
// PORTS
//  HCLK          in   1   clock; everything is rising-edge
//  HRESETN       in   1   synchronous reset, active-low
//  Mx_PSEL       in   1   requester x select (x = 0,1)
//  Mx_PENABLE    in   1   requester x enable
//  Mx_PADDR      in   AW  requester x address
//  Mx_PWRITE     in   1   requester x write
//  Mx_PWDATA     in   DW  requester x write data
//  Mx_PRDATA     out  DW  read data to requester x
//  Mx_PREADY     out  1   transfer complete to requester x
//  Mx_PSLVERR    out  1   error to requester x
//  PSEL,PENABLE,PADDR,PWRITE,PWDATA  out  -  shared APB3 master side (registered)
//  PRDATA        in   DW  shared bus read data
//  PREADY        in   1   shared bus ready
//  PSLVERR       in   1   shared bus error
//  GRANT         out  2   one-hot owner {M1,M0}; 00 in IDLE
//  TIMEOUT_ERR   out  1   one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  - Reset (HRESETN=0 at a clock edge): every output goes to 0 at that edge. State=IDLE,
//    watchdog counter=0, rr_last=M1 (so M0 wins the first tie). A transfer in flight is
//    dropped with no upstream response. This also applies to reset mid-transfer.
//  - Request: reqx = Mx_PSEL, sampled only in IDLE.
//  - FSM:
//    IDLE   : if any reqx, pick owner. Single request: that master. Both: the master
//             that is not rr_last. Latch PADDR/PWRITE/PWDATA from owner; set GRANT; -> SETUP.
//    SETUP  : PSEL=1, PENABLE=0 -> ACCESS.
//    ACCESS : PSEL=1, PENABLE=1. Each cycle with PREADY=0 increments wd_cnt.
//             PREADY=1: capture PRDATA and PSLVERR into resp regs -> RESP.
//             If TIMEOUT!=0 and wd_cnt==TIMEOUT-1 with PREADY=0: resp data=0, resp err=1,
//             pulse TIMEOUT_ERR -> RESP.
//    RESP   : PSEL=PENABLE=0. Owner gets Mx_PREADY=1, Mx_PRDATA=resp data,
//             Mx_PSLVERR=resp err for exactly this cycle. rr_last=owner, wd_cnt=0,
//             GRANT=00 -> IDLE.
//  - Latency: request seen at edge n -> PSEL at n+1, PENABLE at n+2. With zero-wait
//    slave, Mx_PREADY at n+3. Each slave wait state adds 1 cycle. Minimum 4 cycles/transfer.
//  - Non-owner and idle outputs: Mx_PREADY=0, Mx_PRDATA=0, Mx_PSLVERR=0. A losing
//    requester waits in its ACCESS phase; it is re-arbitrated in the next IDLE.
//  - If the owner drops Mx_PSEL mid-transfer (protocol violation): the shared transfer
//    still completes and RESP still occurs; the response is ignored by the requester.
//  - wd_cnt is $clog2(TIMEOUT+1) bits and saturates; PSLVERR is passed through unchanged.
//  - PADDR/PWRITE/PWDATA hold their latched values from SETUP through RESP.
// TESTING
//  1 M0 write 0x100/0xDEADBEEF, PREADY tied 1 -> PSEL@n+1, PENABLE@n+2, M0_PREADY@n+3,
//    PWDATA=0xDEADBEEF, M0_PSLVERR=0, GRANT=01 for n+1..n+3.
//  2 After reset, M0 and M1 request in the same cycle -> M0 served first, then M1. Repeat
//    the simultaneous request -> M1 served first (alternation).
//  3 M1 read at 0x2000, slave adds 3 wait states then PRDATA=0x12345678 -> M1_PREADY@n+6,
//    M1_PRDATA=0x12345678 for 1 cycle.
//  4 TIMEOUT=8, PREADY stuck 0 -> 8 ACCESS cycles, TIMEOUT_ERR pulse, M0_PSLVERR=1,
//    M0_PRDATA=0, PSEL=0 in RESP, next request accepted.
//  5 Slave returns PSLVERR=1 with PREADY=1 -> owner Mx_PSLVERR=1 in RESP only.
//  6 HRESETN=0 for 1 cycle during ACCESS -> all outputs 0 next edge, no Mx_PREADY.
//    A held request is re-served from SETUP after reset release.

Source files
------------

// File: rtl/apb3_two_master_arbiter.sv
// Two-requester APB3 arbiter: round-robin ownership of one shared APB3 bus, with
// regenerated SETUP/ACCESS phases and a PREADY watchdog that ends hung transfers.
module apb3_two_master_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   input  logic                  M0_PSEL,
   input  logic                  M0_PENABLE,
   input  logic [ADDR_WIDTH-1:0] M0_PADDR,
   input  logic                  M0_PWRITE,
   input  logic [DATA_WIDTH-1:0] M0_PWDATA,
   output logic [DATA_WIDTH-1:0] M0_PRDATA,
   output logic                  M0_PREADY,
   output logic                  M0_PSLVERR,
   input  logic                  M1_PSEL,
   input  logic                  M1_PENABLE,
   input  logic [ADDR_WIDTH-1:0] M1_PADDR,
   input  logic                  M1_PWRITE,
   input  logic [DATA_WIDTH-1:0] M1_PWDATA,
   output logic [DATA_WIDTH-1:0] M1_PRDATA,
   output logic                  M1_PREADY,
   output logic                  M1_PSLVERR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic [1:0]            GRANT,
   output logic                  TIMEOUT_ERR
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
   localparam logic [WD_W-1:0] WD_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                           state, state_nxt;
   logic                             owner, owner_nxt, rr_last, timeout_hit;
   logic [WD_W-1:0]                  wd_cnt;
   logic [1:0]                       req, m_pwrite, m_pready, m_pslverr;
   logic [1:0][ADDR_WIDTH-1:0]       m_paddr;
   logic [1:0][DATA_WIDTH-1:0]       m_pwdata, m_prdata;
   logic                             unused_penable;

   // Upstream PENABLE carries no information the arbiter needs; requests key off PSEL.
   assign unused_penable = M0_PENABLE ^ M1_PENABLE;

   assign req      = {M1_PSEL, M0_PSEL};
   assign m_pwrite = {M1_PWRITE, M0_PWRITE};
   assign m_paddr  = {M1_PADDR, M0_PADDR};
   assign m_pwdata = {M1_PWDATA, M0_PWDATA};

   assign M0_PREADY  = m_pready[0];
   assign M1_PREADY  = m_pready[1];
   assign M0_PSLVERR = m_pslverr[0];
   assign M1_PSLVERR = m_pslverr[1];
   assign M0_PRDATA  = m_prdata[0];
   assign M1_PRDATA  = m_prdata[1];

   always_ff @(posedge HCLK) begin
      if (!HRESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = SETUP;
               owner_nxt = (req == 2'b11) ? ~rr_last : req[1];
            end
         end
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               state_nxt = RESP;
            end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shared-bus and response outputs are registered so they change on the same
   // edge as the state they belong to.
   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         owner       <= 1'b0;
         rr_last     <= 1'b1;
         wd_cnt      <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         GRANT       <= 2'b00;
         TIMEOUT_ERR <= 1'b0;
         m_pready    <= '0;
         m_pslverr   <= '0;
         m_prdata    <= '0;
      end else begin
         owner       <= owner_nxt;
         TIMEOUT_ERR <= 1'b0;
         m_pready    <= '0;
         m_pslverr   <= '0;
         m_prdata    <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  PSEL   <= 1'b1;
                  PADDR  <= m_paddr[owner_nxt];
                  PWRITE <= m_pwrite[owner_nxt];
                  PWDATA <= m_pwdata[owner_nxt];
                  GRANT  <= owner_nxt ? 2'b10 : 2'b01;
               end
            end
            SETUP: PENABLE <= 1'b1;
            ACCESS: begin
               if (PREADY || timeout_hit) begin
                  PSEL             <= 1'b0;
                  PENABLE          <= 1'b0;
                  m_pready[owner]  <= 1'b1;
                  m_prdata[owner]  <= timeout_hit ? '0 : PRDATA;
                  m_pslverr[owner] <= timeout_hit ? 1'b1 : PSLVERR;
                  TIMEOUT_ERR      <= timeout_hit;
               end else if (wd_cnt != WD_MAX) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            RESP: begin
               rr_last <= owner;
               wd_cnt  <= '0;
               GRANT   <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb3_two_master_arbiter.sv
// Directed bench for apb3_two_master_arbiter: a vector table of single transfers
// against a configurable slave, plus arbitration, watchdog and reset sequences.
module tb_apb3_two_master_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESETN;
   logic        M0_PSEL, M0_PENABLE, M0_PWRITE;
   logic [31:0] M0_PADDR, M0_PWDATA, M0_PRDATA;
   logic        M0_PREADY, M0_PSLVERR;
   logic        M1_PSEL, M1_PENABLE, M1_PWRITE;
   logic [31:0] M1_PADDR, M1_PWDATA, M1_PRDATA;
   logic        M1_PREADY, M1_PSLVERR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [1:0]  GRANT;
   logic        TIMEOUT_ERR;

   int          checks = 0;
   int          failures = 0;

   // slave model configuration and state
   int          sl_waits = 0;
   logic        sl_stuck = 1'b0;
   logic [31:0] sl_rdata = '0;
   logic        sl_err = 1'b0;
   int          acnt = 0;

   always #5 HCLK = ~HCLK;

   apb3_two_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PADDR(M0_PADDR),
      .M0_PWRITE(M0_PWRITE), .M0_PWDATA(M0_PWDATA), .M0_PRDATA(M0_PRDATA),
      .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
      .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PADDR(M1_PADDR),
      .M1_PWRITE(M1_PWRITE), .M1_PWDATA(M1_PWDATA), .M1_PRDATA(M1_PRDATA),
      .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   // Slave: PREADY rises on ACCESS cycle sl_waits+1 unless stuck; PRDATA driven throughout ACCESS.
   initial begin
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      forever begin
         @(negedge HCLK);
         if (PSEL && PENABLE) acnt = acnt + 1;
         else                 acnt = 0;
         PREADY  = PSEL && PENABLE && !sl_stuck && (acnt > sl_waits);
         PRDATA  = (PSEL && PENABLE) ? sl_rdata : 32'h0;
         PSLVERR = PREADY && sl_err;
      end
   end

   typedef struct {
      int          m;
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        stuck;
      logic [31:0] rdata;
      logic        err;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_to;
      int          exp_acc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   task automatic set_master(input int m, input logic sel, input logic en,
                             input logic [31:0] addr, input logic w, input logic [31:0] wd);
      if (m == 0) begin
         M0_PSEL = sel; M0_PENABLE = en; M0_PADDR = addr; M0_PWRITE = w; M0_PWDATA = wd;
      end else begin
         M1_PSEL = sel; M1_PENABLE = en; M1_PADDR = addr; M1_PWRITE = w; M1_PWDATA = wd;
      end
   endtask

   function automatic logic get_pready(input int m);
      return (m == 0) ? M0_PREADY : M1_PREADY;
   endfunction

   function automatic logic get_pslverr(input int m);
      return (m == 0) ? M0_PSLVERR : M1_PSLVERR;
   endfunction

   function automatic logic [31:0] get_prdata(input int m);
      return (m == 0) ? M0_PRDATA : M1_PRDATA;
   endfunction

   // Called at a negedge with the arbiter idle; returns at the negedge after RESP.
   task automatic run_vec(input int idx, input vec_t v);
      int   lat, acc;
      bit   got, early_to;
      logic [1:0] g;
      g = (v.m == 0) ? 2'b01 : 2'b10;
      sl_waits = v.waits; sl_stuck = v.stuck; sl_rdata = v.rdata; sl_err = v.err;
      set_master(v.m, 1'b1, 1'b0, v.addr, v.w, v.wdata);
      got = 0; lat = 0; acc = 0; early_to = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge HCLK);
         if (c == 1) begin
            chk($sformatf("v%0d_setup_psel", idx), PSEL, 1);
            chk($sformatf("v%0d_setup_penable", idx), PENABLE, 0);
            chk($sformatf("v%0d_grant", idx), GRANT, g);
            chk($sformatf("v%0d_paddr", idx), PADDR, v.addr);
            chk($sformatf("v%0d_pwrite", idx), PWRITE, v.w);
            chk($sformatf("v%0d_pwdata", idx), PWDATA, v.wdata);
            set_master(v.m, 1'b1, 1'b1, v.addr, v.w, v.wdata);
         end
         if (PSEL && PENABLE) acc++;
         if (get_pready(v.m)) begin
            got = 1; lat = c;
         end else if (TIMEOUT_ERR) begin
            early_to = 1;
         end
      end
      chk($sformatf("v%0d_resp_seen", idx), got, 1);
      chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
      chk($sformatf("v%0d_prdata", idx), get_prdata(v.m), v.exp_rd);
      chk($sformatf("v%0d_pslverr", idx), get_pslverr(v.m), v.exp_err);
      chk($sformatf("v%0d_timeout_err", idx), TIMEOUT_ERR, v.exp_to);
      chk($sformatf("v%0d_early_timeout", idx), early_to, 0);
      chk($sformatf("v%0d_resp_psel", idx), {PSEL, PENABLE}, 0);
      chk($sformatf("v%0d_resp_grant", idx), GRANT, g);
      chk($sformatf("v%0d_other_pready", idx), get_pready(1 - v.m), 0);
      set_master(v.m, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);
      chk($sformatf("v%0d_idle_grant", idx), GRANT, 0);
      chk($sformatf("v%0d_idle_resp", idx), {get_pready(v.m), get_pslverr(v.m), TIMEOUT_ERR}, 0);
   endtask

   // Waits (bounded) for master m's PREADY; flags any response to the other master meanwhile.
   task automatic wait_pready(input string name, input int m, output bit ok);
      int other;
      ok = 0; other = 0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge HCLK);
         if (get_pready(m)) ok = 1;
         if (get_pready(1 - m)) other++;
      end
      chk({name, "_done"}, ok, 1);
      chk({name, "_other_pready"}, other, 0);
   endtask

   initial begin
      bit ok;
      vecs[0] = '{0, 1'b1, 32'h100,  32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 3,  32'h0,        1'b0, 1'b0, 1};
      vecs[1] = '{1, 1'b0, 32'h2000, 32'h0,        3, 1'b0, 32'h12345678, 1'b0, 6,  32'h12345678, 1'b0, 1'b0, 4};
      vecs[2] = '{0, 1'b0, 32'h40,   32'h0,        1, 1'b0, 32'hA5A50001, 1'b1, 4,  32'hA5A50001, 1'b1, 1'b0, 2};
      vecs[3] = '{1, 1'b1, 32'h8,    32'h0BADF00D, 0, 1'b0, 32'h0,        1'b1, 3,  32'h0,        1'b1, 1'b0, 1};
      vecs[4] = '{0, 1'b0, 32'h300,  32'h0,        0, 1'b1, 32'hBAD0BAD0, 1'b0, 10, 32'h0,        1'b1, 1'b1, 8};
      vecs[5] = '{1, 1'b0, 32'h44,   32'h0,        7, 1'b0, 32'hCAFE0007, 1'b0, 10, 32'hCAFE0007, 1'b0, 1'b0, 8};

      HRESETN = 1'b0;
      set_master(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      set_master(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(negedge HCLK);
      chk("reset_bus", {PSEL, PENABLE, PWRITE, GRANT, TIMEOUT_ERR}, 0);
      chk("reset_addr_data", {PADDR, PWDATA}, 0);
      chk("reset_upstream", {M0_PREADY, M0_PSLVERR, M1_PREADY, M1_PSLVERR, M0_PRDATA, M1_PRDATA}, 0);
      HRESETN = 1'b1;
      @(negedge HCLK);

      // simultaneous requests straight after reset: M0, then M1, then M0 again
      sl_waits = 0; sl_stuck = 1'b0; sl_rdata = '0; sl_err = 1'b0;
      set_master(0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h11);
      set_master(1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h22);
      @(negedge HCLK);
      chk("arb1_grant", GRANT, 2'b01);
      chk("arb1_paddr", PADDR, 32'h10);
      wait_pready("arb1", 0, ok);
      set_master(0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h33);
      @(negedge HCLK);
      chk("arb_idle_grant", GRANT, 2'b00);
      @(negedge HCLK);
      chk("arb2_grant", GRANT, 2'b10);
      chk("arb2_paddr", PADDR, 32'h20);
      wait_pready("arb2", 1, ok);
      set_master(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);
      @(negedge HCLK);
      chk("arb3_grant", GRANT, 2'b01);
      chk("arb3_paddr", PADDR, 32'h14);
      wait_pready("arb3", 0, ok);
      set_master(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // reset during ACCESS drops the transfer; held request restarts from SETUP
      sl_waits = 0; sl_stuck = 1'b1; sl_rdata = 32'h5A5A5A5A; sl_err = 1'b0;
      set_master(0, 1'b1, 1'b0, 32'h55, 1'b1, 32'h77);
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rst_in_access", {PSEL, PENABLE}, 2'b11);
      HRESETN = 1'b0;
      @(negedge HCLK);
      chk("rst_mid_bus", {PSEL, PENABLE, PWRITE, GRANT, TIMEOUT_ERR}, 0);
      chk("rst_mid_addr_data", {PADDR, PWDATA}, 0);
      chk("rst_mid_upstream", {M0_PREADY, M0_PSLVERR, M0_PRDATA}, 0);
      HRESETN = 1'b1;
      sl_stuck = 1'b0;
      @(negedge HCLK);
      chk("rst_reserve_setup", {PSEL, PENABLE, GRANT}, {1'b1, 1'b0, 2'b01});
      chk("rst_reserve_paddr", PADDR, 32'h55);
      wait_pready("rst_reserve", 0, ok);
      chk("rst_reserve_prdata", M0_PRDATA, 32'h5A5A5A5A);
      set_master(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1);
   end

endmodule
